// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in a dividend bit, trial-subtract
// the divisor magnitude, keep the difference when no borrow occurs.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   diff_s;
  logic             carry_s;

  assign shifted_s = {rem_in[WIDTH-1:0], bit_in};

  // Subtract as add-of-complement; carry-out high means no borrow.
  assign {carry_s, diff_s} = {1'b0, shifted_s} + {1'b0, ~{1'b0, dvsr}} + {{(WIDTH+1){1'b0}}, 1'b1};

  // A bit shifted out of the top guarantees the trial subtraction succeeds.
  assign q_bit   = carry_s | rem_in[WIDTH];
  assign rem_out = q_bit ? diff_s : shifted_s;

endmodule

// File: rtl/seq_divider_32.sv
// Multi-cycle signed/unsigned integer divider, one restoring step per cycle,
// with start/busy/done handshake and registered results.
module seq_divider_32
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CNT_BITS = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  div_state_t          state_r, state_n;
  logic [CNT_BITS-1:0] cnt_r;
  logic [WIDTH:0]      rem_r;
  logic [WIDTH-1:0]    dvd_r;
  logic [WIDTH-1:0]    dvsr_r;
  logic                q_neg_r, r_neg_r, dz_r, ovf_r;
  logic                busy_r, done_r, div_zero_r, overflow_r;
  logic [WIDTH-1:0]    quotient_r, remainder_r;

  logic                dvd_neg_s, dvsr_neg_s, dvsr_zero_s, cnt_last_s;
  logic [WIDTH-1:0]    dvd_mag_s, dvsr_mag_s;
  logic [WIDTH:0]      rem_nx_s;
  logic                q_bit_s;

  assign dvd_neg_s   = is_signed & dividend[WIDTH-1];
  assign dvsr_neg_s  = is_signed & divisor[WIDTH-1];
  assign dvd_mag_s   = dvd_neg_s ? neg2(dividend) : dividend;
  assign dvsr_mag_s  = dvsr_neg_s ? neg2(divisor) : divisor;
  assign dvsr_zero_s = (divisor == {WIDTH{1'b0}});
  assign cnt_last_s  = (cnt_r == CNT_BITS'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .bit_in  (dvd_r[WIDTH-1]),
    .dvsr    (dvsr_r),
    .rem_out (rem_nx_s),
    .q_bit   (q_bit_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_n = dvsr_zero_s ? FIX : CALC;
        end else begin
          state_n = IDLE;
        end
      end
      CALC: begin
        if (cnt_last_s) begin
          state_n = FIX;
        end else begin
          state_n = CALC;
        end
      end
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, iteration datapath, sign fix-up and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= {CNT_BITS{1'b0}};
      rem_r       <= {(WIDTH+1){1'b0}};
      dvd_r       <= {WIDTH{1'b0}};
      dvsr_r      <= {WIDTH{1'b0}};
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      dz_r        <= 1'b0;
      ovf_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      div_zero_r  <= 1'b0;
      overflow_r  <= 1'b0;
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            // On divide-by-zero the raw dividend is kept for the remainder.
            dvd_r   <= dvsr_zero_s ? dividend : dvd_mag_s;
            dvsr_r  <= dvsr_mag_s;
            rem_r   <= {(WIDTH+1){1'b0}};
            cnt_r   <= {CNT_BITS{1'b0}};
            q_neg_r <= dvd_neg_s ^ dvsr_neg_s;
            r_neg_r <= dvd_neg_s;
            dz_r    <= dvsr_zero_s;
            ovf_r   <= is_signed & (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                       & (divisor == {WIDTH{1'b1}});
          end
        end
        CALC: begin
          rem_r <= rem_nx_s;
          dvd_r <= {dvd_r[WIDTH-2:0], q_bit_s};
          cnt_r <= cnt_r + CNT_BITS'(1);
        end
        FIX: begin
          if (dz_r) begin
            quotient_r  <= {WIDTH{1'b1}};
            remainder_r <= dvd_r;
          end else begin
            quotient_r  <= q_neg_r ? neg2(dvd_r) : dvd_r;
            remainder_r <= r_neg_r ? neg2(rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];
          end
          div_zero_r <= dz_r;
          overflow_r <= ovf_r & ~dz_r;
        end
        default: begin
          cnt_r <= {CNT_BITS{1'b0}};
        end
      endcase
      busy_r <= (state_n != IDLE);
      done_r <= (state_r == FIX);
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign div_zero  = div_zero_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_seq_divider_32.sv
// Directed self-checking bench for seq_divider_32 with hand-computed results.
module tb_seq_divider_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        busy, done, div_zero, overflow;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int errors = 0;
  int lat;
  int seen_done;

  seq_divider_32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for done, sampling #1 after each rising edge.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 80) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  // Launch a divide at the next edge and wait for its done pulse.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s, output int cycles);
    @(negedge clk);
    dividend = a; divisor = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cycles);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Unsigned 100 / 7
    run(32'd100, 32'd7, 1'b0, lat);
    check("u100_7_lat", lat, 32'd33);
    check("u100_7_q", quotient, 32'd14);
    check("u100_7_r", remainder, 32'd2);
    check("u100_7_dz", {31'd0, div_zero}, 32'd0);
    check("u100_7_ovf", {31'd0, overflow}, 32'd0);
    check("u100_7_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("done_pulse_width", {31'd0, done}, 32'd0);
    check("q_hold", quotient, 32'd14);

    // Signed -7 / 2
    run(32'hFFFF_FFF9, 32'd2, 1'b1, lat);
    check("sm7_2_q", quotient, 32'hFFFF_FFFD);
    check("sm7_2_r", remainder, 32'hFFFF_FFFF);

    // Signed 7 / -2
    run(32'd7, 32'hFFFF_FFFE, 1'b1, lat);
    check("s7_m2_q", quotient, 32'hFFFF_FFFD);
    check("s7_m2_r", remainder, 32'd1);

    // Divide by zero
    run(32'h1234_5678, 32'd0, 1'b1, lat);
    check("dz_lat", lat, 32'd1);
    check("dz_q", quotient, 32'hFFFF_FFFF);
    check("dz_r", remainder, 32'h1234_5678);
    check("dz_flag", {31'd0, div_zero}, 32'd1);
    check("dz_ovf", {31'd0, overflow}, 32'd0);

    // Signed overflow case and its unsigned counterpart
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
    check("sovf_q", quotient, 32'h8000_0000);
    check("sovf_r", remainder, 32'd0);
    check("sovf_flag", {31'd0, overflow}, 32'd1);
    check("sovf_dz", {31'd0, div_zero}, 32'd0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat);
    check("uovf_q", quotient, 32'd0);
    check("uovf_r", remainder, 32'h8000_0000);
    check("uovf_flag", {31'd0, overflow}, 32'd0);

    // Start during busy is ignored; start in the done cycle is accepted
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd10; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    dividend = 32'd55; divisor = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check("ign_lat", lat, 32'd23);
    check("ign_q", quotient, 32'd100);
    check("ign_r", remainder, 32'd0);
    dividend = 32'd17; divisor = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_q_hold", quotient, 32'd100);
    wait_done(lat);
    check("b2b_lat", lat, 32'd33);
    check("b2b_q", quotient, 32'd3);
    check("b2b_r", remainder, 32'd2);

    // Reset in the middle of an operation
    @(negedge clk);
    dividend = 32'd200; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_done", {31'd0, done}, 32'd0);
    check("mrst_q", quotient, 32'd0);
    check("mrst_r", remainder, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done++;
    end
    check("mrst_no_done", seen_done, 32'd0);
    run(32'd200, 32'd3, 1'b0, lat);
    check("post_rst_lat", lat, 32'd33);
    check("post_rst_q", quotient, 32'd66);
    check("post_rst_r", remainder, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
